// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, RV32 opcode
// constants and the sequential PC increment.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FENCE = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_FENCE  = 7'b0001111;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] PC_STEP    = 32'd4;

    // True for opcodes that redirect the PC unconditionally.
    function automatic logic is_jump_opcode(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

    // True for opcodes that stop or pause sequential fetch.
    function automatic logic is_flow_stop_opcode(input logic [6:0] opcode);
        return (opcode == OPC_FENCE) || (opcode == OPC_SYSTEM);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the decoder/branch unit and the PC sequencer.
// master = decode side (drives strobes, sees PC), slave = sequencer.
interface pc_sequencer_if;

    logic        take_branch;
    logic        is_jalr;
    logic        is_fence;
    logic        is_ecall;
    logic        is_ebreak;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        resume;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        halted;
    logic        misaligned;

    modport master (
        output take_branch, is_jalr, is_fence, is_ecall, is_ebreak,
        output branch_target, jalr_target, resume,
        input  pc, pc_plus4, stall, halted, misaligned
    );

    modport slave (
        input  take_branch, is_jalr, is_fence, is_ecall, is_ebreak,
        input  branch_target, jalr_target, resume,
        output pc, pc_plus4, stall, halted, misaligned
    );

endinterface

// File: rtl/pc_fence_timer.sv
// Down-counter for multi-cycle stalls: load a start value, decrement while
// enabled, done is high whenever the count sits at zero.
module pc_fence_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic       done
);

    logic [7:0] count_reg;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != 8'd0)) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign done = (count_reg == 8'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: sequential fetch,
// branch/jalr redirect with alignment trap, fence pause and ecall/ebreak halt.
// Optional build macro PC_TRACE_STATS_EN adds retired/taken counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FENCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
`ifdef PC_TRACE_STATS_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     taken_cnt
`endif
);

    localparam logic [7:0] FENCE_LOAD = 8'(FENCE_CYCLES - 1);

    seq_state_t  state_reg;
    logic [31:0] pc_reg;
    logic        misaligned_reg;

    logic        halt_req;
    logic        redirect_req;
    logic [31:0] redirect_target;
    logic        target_ok;
    logic [31:0] pc_next_seq;
    logic        timer_load;
    logic        timer_dec;
    logic        timer_done;

    // Decode of the RUN-state request and redirect target.
    always_comb begin
        halt_req        = bus.is_ecall | bus.is_ebreak;
        redirect_req    = bus.is_jalr | bus.take_branch;
        redirect_target = bus.is_jalr ? (bus.jalr_target & ~32'd1)
                                      : bus.branch_target;
        target_ok       = ~redirect_target[1];
        pc_next_seq     = pc_reg + PC_STEP;
        timer_load      = (state_reg == ST_RUN) && !halt_req && bus.is_fence;
        timer_dec       = (state_reg == ST_FENCE);
    end

    pc_fence_timer u_fence_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (FENCE_LOAD),
        .dec        (timer_dec),
        .done       (timer_done)
    );

    // Sequencer FSM owning pc, state and the sticky misaligned flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            pc_reg         <= RESET_PC;
            misaligned_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (halt_req) begin
                        state_reg <= ST_HALT;
                    end else if (bus.is_fence) begin
                        state_reg <= ST_FENCE;
                    end else if (redirect_req) begin
                        if (target_ok) begin
                            pc_reg <= redirect_target;
                        end else begin
                            misaligned_reg <= 1'b1;
                            state_reg      <= ST_HALT;
                        end
                    end else begin
                        pc_reg <= pc_next_seq;
                    end
                end
                ST_FENCE: begin
                    if (timer_done) begin
                        pc_reg    <= pc_next_seq;
                        state_reg <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (bus.resume) begin
                        pc_reg         <= pc_next_seq;
                        misaligned_reg <= 1'b0;
                        state_reg      <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.pc_plus4   = pc_next_seq;
    assign bus.stall      = (state_reg == ST_FENCE);
    assign bus.halted     = (state_reg == ST_HALT);
    assign bus.misaligned = misaligned_reg;

`ifdef PC_TRACE_STATS_EN
    logic        retire_evt;
    logic        taken_evt;
    logic [31:0] retired_reg;
    logic [31:0] taken_reg;

    // Events mirror the PC updates made by the FSM outside HALT.
    always_comb begin
        taken_evt  = (state_reg == ST_RUN) && !halt_req && !bus.is_fence &&
                     redirect_req && target_ok;
        retire_evt = taken_evt ||
                     ((state_reg == ST_RUN) && !halt_req && !bus.is_fence &&
                      !redirect_req) ||
                     ((state_reg == ST_FENCE) && timer_done);
    end

    // Free-running wrap-around statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= 32'd0;
            taken_reg   <= 32'd0;
        end else begin
            if (retire_evt) retired_reg <= retired_reg + 32'd1;
            if (taken_evt)  taken_reg   <= taken_reg + 32'd1;
        end
    end

    assign retired_cnt = retired_reg;
    assign taken_cnt   = taken_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC/flag values.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_sequencer_if bus ();

`ifdef PC_TRACE_STATS_EN
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;
`endif

    pc_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .FENCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef PC_TRACE_STATS_EN
        ,
        .retired_cnt (retired_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.take_branch   = 1'b0;
        bus.is_jalr       = 1'b0;
        bus.is_fence      = 1'b0;
        bus.is_ecall      = 1'b0;
        bus.is_ebreak     = 1'b0;
        bus.branch_target = 32'h0;
        bus.jalr_target   = 32'h0;
        bus.resume        = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        bus.take_branch   = 1'b1;
        bus.branch_target = tgt;
        step();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", bus.pc, 32'h0);
        check("reset_stall", {31'd0, bus.stall}, 32'd0);
        check("reset_halted", {31'd0, bus.halted}, 32'd0);
        check("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);
        check("reset_pc_plus4", bus.pc_plus4, 32'h4);
        rst_n = 1'b1;

        // Sequential flow
        step(); check("seq_1", bus.pc, 32'h4);
        step(); check("seq_2", bus.pc, 32'h8);
        step(); check("seq_3", bus.pc, 32'hC);
        check("seq_stall", {31'd0, bus.stall}, 32'd0);
        step(); check("seq_4", bus.pc, 32'h10);

        // Branch taken
        branch_to(32'h40);
        check("branch_pc", bus.pc, 32'h40);
        branch_to(32'h10);
        check("branch_back", bus.pc, 32'h10);

        // Branch together with ecall: ecall wins, halt
        bus.take_branch = 1'b1; bus.branch_target = 32'h40; bus.is_ecall = 1'b1;
        step(); idle_inputs();
        check("ecall_pc", bus.pc, 32'h10);
        check("ecall_halted", {31'd0, bus.halted}, 32'd1);
        step();
        check("halt_hold_pc", bus.pc, 32'h10);
        check("halt_hold", {31'd0, bus.halted}, 32'd1);
        bus.resume = 1'b1;
        step();
        check("resume_pc", bus.pc, 32'h14);
        check("resume_halted", {31'd0, bus.halted}, 32'd0);
        step();
        check("resume_held_once", bus.pc, 32'h18);
        bus.resume = 1'b0;

        // ebreak also halts
        bus.is_ebreak = 1'b1;
        step(); idle_inputs();
        check("ebreak_halted", {31'd0, bus.halted}, 32'd1);
        check("ebreak_pc", bus.pc, 32'h18);
        bus.resume = 1'b1; step(); bus.resume = 1'b0;
        check("ebreak_resume_pc", bus.pc, 32'h1C);

        // Fence: frozen 4 cycles, resume ignored meanwhile
        branch_to(32'h20);
        check("fence_start_pc", bus.pc, 32'h20);
        bus.is_fence = 1'b1;
        step();
        bus.is_fence = 1'b0;
        bus.resume   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fence_stall_%0d", i), {31'd0, bus.stall}, 32'd1);
            check($sformatf("fence_pc_%0d", i), bus.pc, 32'h20);
            step();
        end
        bus.resume = 1'b0;
        check("fence_exit_pc", bus.pc, 32'h24);
        check("fence_exit_stall", {31'd0, bus.stall}, 32'd0);

        // jalr: bit 0 cleared, then misaligned target traps
        branch_to(32'h8);
        bus.is_jalr = 1'b1; bus.jalr_target = 32'h101;
        step();
        check("jalr_pc", bus.pc, 32'h100);
        check("jalr_misaligned", {31'd0, bus.misaligned}, 32'd0);
        bus.jalr_target = 32'h102;
        step(); idle_inputs();
        check("jalr_mis_pc", bus.pc, 32'h100);
        check("jalr_mis_flag", {31'd0, bus.misaligned}, 32'd1);
        check("jalr_mis_halted", {31'd0, bus.halted}, 32'd1);
        step();
        check("mis_sticky", {31'd0, bus.misaligned}, 32'd1);
        bus.resume = 1'b1; step(); bus.resume = 1'b0;
        check("mis_resume_pc", bus.pc, 32'h104);
        check("mis_resume_flag", {31'd0, bus.misaligned}, 32'd0);

        // Misaligned branch target also traps
        branch_to(32'h202);
        check("br_mis_pc", bus.pc, 32'h104);
        check("br_mis_flag", {31'd0, bus.misaligned}, 32'd1);
        bus.resume = 1'b1; step(); bus.resume = 1'b0;
        check("br_mis_resume_pc", bus.pc, 32'h108);

        // Wrap-around
        bus.is_jalr = 1'b1; bus.jalr_target = 32'hFFFF_FFFC;
        step(); idle_inputs();
        check("wrap_top", bus.pc, 32'hFFFF_FFFC);
        check("wrap_plus4", bus.pc_plus4, 32'h0);
        step();
        check("wrap_zero", bus.pc, 32'h0);
        check("wrap_no_flag", {31'd0, bus.misaligned}, 32'd0);
        step();
        check("wrap_next", bus.pc, 32'h4);

        // Asynchronous reset in the middle of a fence
        bus.is_fence = 1'b1;
        step(); bus.is_fence = 1'b0;
        step();
        check("fence_mid_stall", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, 32'h0);
        check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_pc", bus.pc, 32'h4);
        check("post_rst_stall", {31'd0, bus.stall}, 32'd0);

`ifdef PC_TRACE_STATS_EN
        rst_n = 1'b0; #2; rst_n = 1'b1;
        check("stats_rst_retired", retired_cnt, 32'd0);
        repeat (5) step();
        branch_to(32'h80);
        branch_to(32'h100);
        check("stats_retired", retired_cnt, 32'd7);
        check("stats_taken", taken_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Runaway guard
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the single-cycle core.
- Consumes the branch decision (take_branch) and instruction-class strobes, then registers the next PC.
- Implements fence pause, ecall/ebreak halt, misaligned-target trap and restart.
- Sits between the branch control unit / decoder and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FENCE_CYCLES, 4, number of cycles the PC is frozen for fence/pause (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- take_branch  in  1  branch/jal redirect request from the branch control unit.
- is_jalr  in  1  current instruction is jalr.
- is_fence  in  1  current instruction is fence/pause.
- is_ecall  in  1  current instruction is ecall.
- is_ebreak  in  1  current instruction is ebreak.
- branch_target  in  32  pc+imm target for branch/jal.
- jalr_target  in  32  rs1+imm target for jalr.
- resume  in  1  single-cycle pulse that restarts from HALT.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc+4, combinational, modulo 2^32 (link value).
- stall  out  1  high while in FENCE state.
- halted  out  1  high while in HALT state.
- misaligned  out  1  sticky; set when a redirect target is not 4-byte aligned.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, state=RUN, counter=0.
  - stall=0, halted=0, misaligned=0.
  - Deassertion is sampled on the next rising edge.
- States: RUN, FENCE, HALT. stall and halted are decoded from the state register, so there are no glitches.
- Instruction inputs are sampled only in RUN. They are ignored in FENCE and HALT.
- RUN priority, highest first:
  - is_ecall or is_ebreak: pc held; next state HALT. halted is visible on the following cycle.
  - is_fence: pc held; counter=FENCE_CYCLES-1; next state FENCE.
  - is_jalr: target={jalr_target[31:1],1'b0}.
  - take_branch: target=branch_target.
  - Otherwise: pc<=pc+4.
- take_branch may be asserted together with fence/ecall/ebreak. Priority resolves this; take_branch is ignored in that case.
- Redirect alignment check (jalr or take_branch): if target[1]==1, pc is held, misaligned is set, next state is HALT. Otherwise pc<=target.
- FENCE:
  - Counter decrements every cycle.
  - When the counter is 0: pc<=pc+4 and next state is RUN.
  - Total frozen cycles = FENCE_CYCLES; the instruction after the fence is visible FENCE_CYCLES+1 cycles after the fence.
  - resume is ignored in FENCE.
- HALT:
  - pc is held.
  - resume=1: pc<=pc+4, misaligned cleared, next state RUN.
  - resume held high for several cycles acts once; after leaving HALT the core is in RUN, where resume has no effect.
- Wrap-around: pc 32'hFFFF_FFFC with sequential flow goes to 32'h0000_0000, with no flag.
- Reset mid-FENCE or mid-HALT returns immediately to RESET_PC/RUN; the counter is cleared.

Optional Feature:
- PC_TRACE_STATS_EN defined:
  - Adds outputs retired_cnt[31:0] and taken_cnt[31:0].
  - retired_cnt increments on every PC update out of RUN or FENCE-exit.
  - taken_cnt increments on every accepted aligned redirect (jalr or take_branch).
  - Both counters wrap, reset to 0, and are held in HALT.
- PC_TRACE_STATS_EN undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package holds:
  - state encoding typedef (RUN=2'd0, FENCE=2'd1, HALT=2'd2);
  - opcode constants (JAL 7'b1101111, JALR 7'b1100111, FENCE 7'b0001111, SYSTEM 7'b1110011);
  - PC_STEP=4.
- One natural sub-module: pc_fence_timer (load, decrement, done flag), reusable for later multi-cycle stalls.
- The next-PC mux and FSM stay in pc_sequencer.

Test Plan:
- Reset, then 3 idle cycles -> pc goes 0x0, 0x4, 0x8, 0xC; stall=0, halted=0.
- pc=0x10, take_branch=1, branch_target=0x40 -> pc=0x40 next cycle. Same again with is_ecall=1 -> pc stays 0x10 and halted=1.
- pc=0x20, is_fence=1, FENCE_CYCLES=4 -> stall high 4 cycles, pc held at 0x20, then pc=0x24.
- pc=0x8, is_jalr=1, jalr_target=0x101 -> pc=0x100. Next, jalr_target=0x102 -> pc held at 0x100, misaligned=1, halted=1. resume pulse -> pc=0x104, misaligned=0.
- pc=0xFFFF_FFFC sequential -> pc=0x0. Assert rst_n low during FENCE -> pc=RESET_PC immediately, stall=0.
- With PC_TRACE_STATS_EN: 5 sequential + 2 taken branches -> retired_cnt=7, taken_cnt=2.
